cce_cfg_sequencer: RTL and testbench

- Boot-time configuration master for a coherence engine (CCE).
- After reset it issues an ordered stream of memory-mapped config writes over an IO command channel:
  - assert freeze
  - load microcode RAM from an external instruction ROM
  - set the CCE operating mode
  - optionally clear freeze
- Asserts done_o once every write has been acknowledged. It sits between the instruction ROM and the config bus slave.

---
 rtl/cce_cfg_sequencer_if.sv | 30 +++
 rtl/cce_cfg_sequencer.sv | 149 ++++++++++++++
 tb/tb_cce_cfg_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cce_cfg_sequencer_if.sv
// IO command / response channel between the CCE config sequencer and the
// config bus slave. Signal names keep the sequencer-side direction suffix.
interface cce_cfg_sequencer_if #(
  parameter int paddr_width_p  = 40,
  parameter int lce_id_width_p = 4
) ();

  logic                      io_cmd_v_o;
  logic [paddr_width_p-1:0]  io_cmd_addr_o;
  logic [63:0]               io_cmd_data_o;
  logic [lce_id_width_p-1:0] io_cmd_lce_id_o;
  logic                      io_cmd_yumi_i;
  logic                      io_resp_v_i;
  logic                      io_resp_ready_o;

  // Sequencer side: issues commands, consumes acknowledges
  modport master (
    output io_cmd_v_o, io_cmd_addr_o, io_cmd_data_o, io_cmd_lce_id_o,
    output io_resp_ready_o,
    input  io_cmd_yumi_i, io_resp_v_i
  );

  // Config bus slave side
  modport slave (
    input  io_cmd_v_o, io_cmd_addr_o, io_cmd_data_o, io_cmd_lce_id_o,
    input  io_resp_ready_o,
    output io_cmd_yumi_i, io_resp_v_i
  );

endinterface

// File: rtl/cce_cfg_sequencer.sv
// Boot-time configuration master for the coherence engine. After reset it
// freezes the CCE, copies the instruction ROM into microcode RAM, sets the
// operating mode, optionally unfreezes, then waits for every write to be
// acknowledged before raising done_o.
module cce_cfg_sequencer #(
  parameter int          paddr_width_p         = 40,
  parameter int          lce_id_width_p        = 4,
  parameter int          inst_width_p          = 48,
  parameter int          inst_ram_addr_width_p = 8,
  parameter int          inst_ram_els_p        = 256,
  parameter bit          skip_ram_init_p       = 1'b0,
  parameter bit          clear_freeze_p        = 1'b1,
  parameter int          credits_p             = 8,
  parameter logic [63:0] cfg_base_addr_p       = 64'h20_0000
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [lce_id_width_p-1:0]        lce_id_i,
  output logic [inst_ram_addr_width_p-1:0] rom_addr_o,
  input  logic [inst_width_p-1:0]          rom_data_i,
  cce_cfg_sequencer_if.master              io_cmd,
  output logic                             done_o
);

  localparam int credit_width_lp = $clog2(credits_p + 1);
  localparam logic [credit_width_lp-1:0] credits_lp = credit_width_lp'(credits_p);
  localparam logic [inst_ram_addr_width_p-1:0] last_index_lp =
    inst_ram_addr_width_p'(inst_ram_els_p - 1);

  localparam logic [paddr_width_p-1:0] freeze_addr_lp =
    paddr_width_p'(cfg_base_addr_p + 64'h008);
  localparam logic [paddr_width_p-1:0] mode_addr_lp =
    paddr_width_p'(cfg_base_addr_p + 64'h010);
  localparam logic [paddr_width_p-1:0] ucode_base_lp =
    paddr_width_p'(cfg_base_addr_p + 64'h8000);

  typedef enum logic [2:0] {
    S_RESET,
    S_FREEZE,
    S_UCODE,
    S_MODE,
    S_UNFREEZE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                           state_reg;
  logic [inst_ram_addr_width_p-1:0] index_reg;
  logic [credit_width_lp-1:0]       credit_reg;
  logic                             done_reg;

  logic                             cmd_state;
  logic                             cmd_v;
  logic                             accept;
  logic [paddr_width_p-1:0]         cmd_addr;
  logic [63:0]                      cmd_data;

  // Valid is decoded purely from registers, so a response that frees the
  // last credit only re-enables issue on the following cycle.
  assign cmd_state = (state_reg == S_FREEZE) || (state_reg == S_UCODE) ||
                     (state_reg == S_MODE)   || (state_reg == S_UNFREEZE);
  assign cmd_v     = cmd_state && (credit_reg < credits_lp);
  assign accept    = cmd_v && io_cmd.io_cmd_yumi_i;

  // Address/data for the write presented in the current state; the ROM
  // word is used combinationally since it follows rom_addr_o in-cycle.
  always_comb begin
    cmd_addr = freeze_addr_lp;
    cmd_data = '0;
    case (state_reg)
      S_FREEZE: begin
        cmd_addr = freeze_addr_lp;
        cmd_data = 64'd1;
      end
      S_UCODE: begin
        cmd_addr = ucode_base_lp + (paddr_width_p'(index_reg) << 3);
        cmd_data = 64'(rom_data_i);
      end
      S_MODE: begin
        cmd_addr = mode_addr_lp;
        cmd_data = 64'd1;
      end
      S_UNFREEZE: begin
        cmd_addr = freeze_addr_lp;
        cmd_data = 64'd0;
      end
      default: begin
        cmd_addr = freeze_addr_lp;
        cmd_data = '0;
      end
    endcase
  end

  // Outstanding-command counter; a response with nothing outstanding (for
  // example one left over from before a reset) is dropped.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_reg <= '0;
    end else if (accept && !io_cmd.io_resp_v_i) begin
      credit_reg <= credit_reg + 1'b1;
    end else if (!accept && io_cmd.io_resp_v_i && (credit_reg != '0)) begin
      credit_reg <= credit_reg - 1'b1;
    end
  end

  // Sequencing FSM: one config write per command state, then drain.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= S_RESET;
      index_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_RESET:    state_reg <= S_FREEZE;
        S_FREEZE:   if (accept) state_reg <= skip_ram_init_p ? S_MODE : S_UCODE;
        S_UCODE: begin
          if (accept) begin
            if (index_reg == last_index_lp) begin
              // Parking the index at 0 keeps rom_addr_o quiet afterwards
              index_reg <= '0;
              state_reg <= S_MODE;
            end else begin
              index_reg <= index_reg + 1'b1;
            end
          end
        end
        S_MODE:     if (accept) state_reg <= clear_freeze_p ? S_UNFREEZE : S_DRAIN;
        S_UNFREEZE: if (accept) state_reg <= S_DRAIN;
        S_DRAIN: begin
          if (credit_reg == '0) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end
        end
        S_DONE:     state_reg <= S_DONE;
        default:    state_reg <= S_RESET;
      endcase
    end
  end

  assign rom_addr_o             = index_reg;
  assign io_cmd.io_cmd_v_o      = cmd_v;
  assign io_cmd.io_cmd_addr_o   = cmd_addr;
  assign io_cmd.io_cmd_data_o   = cmd_data;
  assign io_cmd.io_cmd_lce_id_o = lce_id_i;
  assign io_cmd.io_resp_ready_o = 1'b1;
  assign done_o                 = done_reg;

endmodule

// File: tb/tb_cce_cfg_sequencer.sv
// Randomized bench for cce_cfg_sequencer. Three instances run side by side:
//   dut0: 4 ucode words, unfreeze on (full load, backpressure, mid reset)
//   dut1: ucode skipped, no unfreeze (with spurious responses)
//   dut2: 12 ucode words, responses withheld to hit the credit limit
// The reference model is the expected list of writes plus an outstanding
// count updated by the credit rules.
module tb_cce_cfg_sequencer;

  localparam int          NDUT    = 3;
  localparam int          CREDITS = 8;
  localparam logic [39:0] BASE    = 40'h20_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  lce_id;
  logic [47:0] rom_mem [256];

  logic        v        [NDUT];
  logic        yumi     [NDUT];
  logic        resp_v   [NDUT];
  logic        done     [NDUT];
  logic        resp_rdy [NDUT];
  logic [39:0] addr     [NDUT];
  logic [63:0] data     [NDUT];
  logic [7:0]  rom_addr [NDUT];
  logic [47:0] rom_data [NDUT];
  logic [3:0]  lce_out  [NDUT];

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      cce_cfg_sequencer_if #(.paddr_width_p(40), .lce_id_width_p(4)) io_if ();

      assign io_if.io_cmd_yumi_i = yumi[gi];
      assign io_if.io_resp_v_i   = resp_v[gi];
      assign v[gi]        = io_if.io_cmd_v_o;
      assign addr[gi]     = io_if.io_cmd_addr_o;
      assign data[gi]     = io_if.io_cmd_data_o;
      assign lce_out[gi]  = io_if.io_cmd_lce_id_o;
      assign resp_rdy[gi] = io_if.io_resp_ready_o;
      assign rom_data[gi] = rom_mem[rom_addr[gi]];

      cce_cfg_sequencer #(
        .paddr_width_p        (40),
        .lce_id_width_p       (4),
        .inst_width_p         (48),
        .inst_ram_addr_width_p(8),
        .inst_ram_els_p       ((gi == 2) ? 12 : 4),
        .skip_ram_init_p      (gi == 1),
        .clear_freeze_p       (gi != 1),
        .credits_p            (CREDITS),
        .cfg_base_addr_p      (64'h20_0000)
      ) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .lce_id_i   (lce_id),
        .rom_addr_o (rom_addr[gi]),
        .rom_data_i (rom_data[gi]),
        .io_cmd     (io_if),
        .done_o     (done[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int n_acc  [NDUT];
  int cred   [NDUT];
  int pend   [NDUT];
  bit done_m [NDUT];
  int yumi_pct [NDUT];
  int resp_pct [NDUT];
  int spur_pct [NDUT];
  bit hold_resp [NDUT];
  int stall_cyc;
  int bp_cnt;
  bit bp_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int n_ucode(input int k);
    return (k == 1) ? 0 : ((k == 2) ? 12 : 4);
  endfunction

  function automatic int n_writes(input int k);
    return 2 + n_ucode(k) + ((k == 1) ? 0 : 1);
  endfunction

  // n-th write of the boot sequence for instance k
  function automatic void exp_write(input int k, input int n,
                                    output logic [39:0] a, output logic [63:0] d);
    int u;
    u = n_ucode(k);
    if (n == 0) begin
      a = BASE + 40'h008; d = 64'd1;
    end else if (n <= u) begin
      a = BASE + 40'h8000 + 40'(8 * (n - 1));
      d = {16'h0, rom_mem[n-1]};
    end else if (n == u + 1) begin
      a = BASE + 40'h010; d = 64'd1;
    end else begin
      a = BASE + 40'h008; d = 64'd0;
    end
  endfunction

  // One clock cycle: check outputs against the model, drive yumi/resp,
  // advance the model, then move to the next falling edge.
  task automatic step();
    for (int k = 0; k < NDUT; k++) begin
      int          total;
      bit          exp_v;
      bit          acc;
      bit          r;
      logic [39:0] ea;
      logic [63:0] ed;

      total = n_writes(k);
      exp_v = (n_acc[k] < total) && (cred[k] < CREDITS);
      check_eq($sformatf("dut%0d valid", k), 64'(v[k]), 64'(exp_v));
      check_eq($sformatf("dut%0d done", k), 64'(done[k]), 64'(done_m[k]));
      if (n_acc[k] == total && cred[k] == 0) done_m[k] = 1'b1;

      yumi[k] = 1'b0;
      if (v[k]) begin
        if (k == 0 && !bp_done && n_acc[0] == 3) begin
          check_eq("bp addr", 64'(addr[0]), 64'(BASE + 40'h8010));
          check_eq("bp data", data[0], {16'h0, rom_mem[2]});
          check_eq("bp rom_addr", 64'(rom_addr[0]), 64'd2);
          bp_cnt++;
          if (bp_cnt == 5) bp_done = 1'b1;
        end else begin
          yumi[k] = ($urandom_range(0, 99) < yumi_pct[k]);
        end
      end
      acc = v[k] && yumi[k];

      if (acc) begin
        exp_write(k, n_acc[k], ea, ed);
        $display("dut%0d write %0d addr=%h data=%h", k, n_acc[k], addr[k], data[k]);
        check_eq($sformatf("dut%0d addr", k), 64'(addr[k]), 64'(ea));
        check_eq($sformatf("dut%0d data", k), data[k], ed);
        check_eq($sformatf("dut%0d lce", k), 64'(lce_out[k]), 64'(lce_id));
        check_eq($sformatf("dut%0d resp_ready", k), 64'(resp_rdy[k]), 64'd1);
        if (n_acc[k] >= 1 && n_acc[k] <= n_ucode(k))
          check_eq($sformatf("dut%0d rom_addr", k), 64'(rom_addr[k]), 64'(n_acc[k] - 1));
        n_acc[k]++;
      end

      r = 1'b0;
      if (hold_resp[k]) begin
        if (cred[k] == CREDITS && !v[k]) stall_cyc++;
        if (stall_cyc == 3) begin
          check_eq("credit accepts", 64'(n_acc[k]), 64'(CREDITS));
          r = 1'b1;
          hold_resp[k] = 1'b0;
        end
      end else if (pend[k] > 0) begin
        r = ($urandom_range(0, 99) < resp_pct[k]);
      end else begin
        r = ($urandom_range(0, 99) < spur_pct[k]);
      end
      resp_v[k] = r;

      if (r && pend[k] > 0) pend[k]--;
      if (acc && !r)                     cred[k]++;
      else if (!acc && r && cred[k] > 0) cred[k]--;
      if (acc) pend[k]++;
    end
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, then releases.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      yumi[k]   = 1'b0;
      resp_v[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("dut%0d reset valid", k), 64'(v[k]), 64'd0);
      check_eq($sformatf("dut%0d reset done", k), 64'(done[k]), 64'd0);
      check_eq($sformatf("dut%0d reset rom_addr", k), 64'(rom_addr[k]), 64'd0);
      n_acc[k]  = 0;
      cred[k]   = 0;
      done_m[k] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_phase(input bit mid_reset);
    int budget;
    bit fin;
    bit mid_done;
    budget   = 0;
    fin      = 1'b0;
    mid_done = 1'b0;
    while (!fin && budget < 3000) begin
      if (mid_reset && !mid_done && n_acc[0] == 2 && v[0]) begin
        do_reset();
        mid_done = 1'b1;
      end
      step();
      budget++;
      fin = 1'b1;
      for (int k = 0; k < NDUT; k++)
        if (!done_m[k] || pend[k] != 0 || !done[k]) fin = 1'b0;
    end
    check_eq("phase finished", 64'(fin), 64'd1);
    repeat (5) step();
  endtask

  initial begin
    rst_n  = 1'b0;
    lce_id = 4'ha;
    for (int i = 0; i < 256; i++) rom_mem[i] = {16'($urandom), $urandom};
    for (int k = 0; k < NDUT; k++) begin
      yumi[k] = 1'b0; resp_v[k] = 1'b0;
      n_acc[k] = 0; cred[k] = 0; pend[k] = 0; done_m[k] = 1'b0;
      hold_resp[k] = 1'b0;
    end
    yumi_pct = '{60, 70, 100};
    resp_pct = '{50, 70, 60};
    spur_pct = '{0, 10, 0};
    stall_cyc = 0;
    bp_cnt    = 0;
    bp_done   = 1'b0;

    @(negedge clk);
    do_reset();
    hold_resp[2] = 1'b1;
    run_phase(1'b0);
    check_eq("bp cycles", 64'(bp_cnt), 64'd5);

    do_reset();
    run_phase(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
